mc_responder: RTL and testbench

Memory-controller responder model for the PHOLD simulation fabric. It accepts the request side of the MC port (`mc_rq_*`) that the PHOLD top and its cores drive, executes 64-bit reads and writes against a local word-addressed store, and returns in-order responses on `mc_rs_*` after a fixed pipeline latency. It provides request back-pressure and honours response back-pressure. It lets the event engine run self-contained in simulation and on boards without the host memory controller.

---
 rtl/mc_responder.sv | 156 +++++++++++++++
 tb/tb_mc_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_responder.sv
// mc_responder: memory-controller responder model for the PHOLD fabric.
// Requests are queued in a FIFO and popped in order into a fixed-length
// pipeline. The store is accessed at the pop edge. The last pipeline stage
// is the response register set on mc_rs_*.
module mc_responder #(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int MEM_AW          = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int LATENCY         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mc_rq_vld,
    input  logic [2:0]                 mc_rq_cmd,
    input  logic [3:0]                 mc_rq_scmd,
    input  logic [47:0]                mc_rq_vadr,
    input  logic [1:0]                 mc_rq_size,
    input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic [63:0]                mc_rq_data,
    input  logic                       mc_rq_flush,
    output logic                       mc_rq_stall,
    output logic                       mc_rs_vld,
    output logic [2:0]                 mc_rs_cmd,
    output logic [3:0]                 mc_rs_scmd,
    output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    output logic [63:0]                mc_rs_data,
    input  logic                       mc_rs_stall,
    output logic                       err_cmd
);

    // Stage STAGES-1 is the response register set itself.
    localparam int STAGES = LATENCY - 1;
    localparam int FAW    = $clog2(FIFO_DEPTH);
    localparam int CW     = FAW + 1;
    localparam int WORDS  = 1 << MEM_AW;

    typedef struct packed {
        logic                       flush;
        logic [2:0]                 cmd;
        logic [MEM_AW-1:0]          idx;
        logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
        logic [63:0]                data;
    } rq_t;

    typedef struct packed {
        logic [2:0]                 cmd;
        logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
        logic [63:0]                data;
    } rs_t;

    rq_t            r_fifo [FIFO_DEPTH];
    logic [FAW-1:0] r_wp;
    logic [FAW-1:0] r_rp;
    logic [CW-1:0]  r_cnt;
    logic [63:0]    r_mem [WORDS];
    logic [STAGES-1:0] r_vld_pipe;
    rs_t            r_pipe [STAGES];
    logic           r_err_cmd;

    logic w_push;
    logic w_adv;
    logic w_pop;
    logic w_is_rd;
    logic w_is_wr;
    logic w_ok;
    logic w_s0_vld;
    rq_t  w_head;
    rs_t  w_s0;
    logic w_unused;

    // Fields the model does not use: scmd, size, address bits outside the word index.
    assign w_unused = ^{mc_rq_scmd, mc_rq_size, mc_rq_vadr[47:MEM_AW+3], mc_rq_vadr[2:0]};

    // Stall comes only from the registered count, so it has no input path.
    assign mc_rq_stall = (r_cnt == CW'(FIFO_DEPTH));
    assign w_push      = mc_rq_vld & ~mc_rq_stall;
    assign w_adv       = ~(r_vld_pipe[STAGES-1] & mc_rs_stall);
    assign w_pop       = w_adv & (r_cnt != '0);
    assign w_head      = r_fifo[r_rp];

    // Decode the FIFO head and build the stage-0 payload; bubbles carry zeros.
    always_comb begin
        w_is_rd  = ~w_head.flush & (w_head.cmd == 3'd1);
        w_is_wr  = ~w_head.flush & (w_head.cmd == 3'd2);
        w_ok     = w_head.flush | w_is_rd | w_is_wr;
        w_s0_vld = w_pop & w_ok;
        w_s0     = '0;
        if (w_s0_vld) begin
            w_s0.cmd    = w_is_rd ? 3'd2 : 3'd3;
            w_s0.rtnctl = w_head.rtnctl;
            w_s0.data   = w_is_rd ? r_mem[w_head.idx] : 64'd0;
        end
    end

    // FIFO storage; pointers live in the reset domain below.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wp] <= '{flush:  mc_rq_flush,
                              cmd:    mc_rq_cmd,
                              idx:    mc_rq_vadr[3 +: MEM_AW],
                              rtnctl: mc_rq_rtnctl,
                              data:   mc_rq_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + FAW'(1);
            if (w_pop)  r_rp <= r_rp + FAW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Word store: written at the pop edge, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_pop & w_is_wr) r_mem[w_head.idx] <= w_head.data;
    end

    // Response pipeline; freezes as a whole while a response is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
        end else if (w_adv) begin
            r_vld_pipe[0] <= w_s0_vld;
            r_pipe[0]     <= w_s0;
            for (int i = 1; i < STAGES; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_pipe[i]     <= r_pipe[i-1];
            end
        end
    end

    // Sticky flag for dropped unsupported commands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               r_err_cmd <= 1'b0;
        else if (w_pop & ~w_ok)  r_err_cmd <= 1'b1;
    end

    assign mc_rs_vld    = r_vld_pipe[STAGES-1];
    assign mc_rs_cmd    = r_pipe[STAGES-1].cmd;
    assign mc_rs_scmd   = 4'd0;
    assign mc_rs_rtnctl = r_pipe[STAGES-1].rtnctl;
    assign mc_rs_data   = r_pipe[STAGES-1].data;
    assign err_cmd      = r_err_cmd;

endmodule

// File: tb/tb_mc_responder.sv
// Directed bench for mc_responder at default parameters.
module tb_mc_responder;

    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mc_rq_vld = 1'b0;
    logic [2:0]    mc_rq_cmd = '0;
    logic [3:0]    mc_rq_scmd = '0;
    logic [47:0]   mc_rq_vadr = '0;
    logic [1:0]    mc_rq_size = '0;
    logic [RW-1:0] mc_rq_rtnctl = '0;
    logic [63:0]   mc_rq_data = '0;
    logic          mc_rq_flush = 1'b0;
    logic          mc_rq_stall;
    logic          mc_rs_vld;
    logic [2:0]    mc_rs_cmd;
    logic [3:0]    mc_rs_scmd;
    logic [RW-1:0] mc_rs_rtnctl;
    logic [63:0]   mc_rs_data;
    logic          mc_rs_stall = 1'b0;
    logic          err_cmd;

    localparam logic [63:0] WDAT = 64'hDEADBEEF_01234567;

    int nchk = 0;
    int nerr = 0;
    int nacc;
    logic acc;
    int got_n;
    logic [RW-1:0] got_tag  [32];
    logic [63:0]   got_data [32];
    logic [2:0]    got_cmd  [32];

    mc_responder dut (
        .clk(clk), .reset(reset),
        .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
        .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
        .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
        .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
        .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall),
        .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rq(input logic v, input logic [2:0] c, input logic [47:0] a,
                      input logic [RW-1:0] t, input logic [63:0] d, input logic f);
        mc_rq_vld    = v;
        mc_rq_cmd    = c;
        mc_rq_vadr   = a;
        mc_rq_rtnctl = t;
        mc_rq_data   = d;
        mc_rq_flush  = f;
    endtask

    // Run a fixed number of cycles and record every response that transfers.
    task automatic collect(input int budget);
        got_n = 0;
        repeat (budget) begin
            if (mc_rs_vld && !mc_rs_stall) begin
                if (got_n < 32) begin
                    got_tag[got_n]  = mc_rs_rtnctl;
                    got_data[got_n] = mc_rs_data;
                    got_cmd[got_n]  = mc_rs_cmd;
                end
                got_n++;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, during and after reset
        #12;
        chk("rst_vld", 64'(mc_rs_vld), 64'd0);
        chk("rst_rqstall", 64'(mc_rq_stall), 64'd0);
        chk("rst_err", 64'(err_cmd), 64'd0);
        chk("rst_data", mc_rs_data, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_vld", 64'(mc_rs_vld), 64'd0);
        chk("post_rst_scmd", 64'(mc_rs_scmd), 64'd0);

        // Write then read, with latency checks
        rq(1, 3'd2, 48'h40, 32'h11, WDAT, 0);
        tick();                                      // edge E
        rq(1, 3'd1, 48'h40, 32'h12, 64'd0, 0);
        tick();                                      // E+1
        rq(0, 3'd0, 48'h0, 32'h0, 64'd0, 0);
        tick();                                      // E+2
        chk("lat_early_vld", 64'(mc_rs_vld), 64'd0);
        tick();                                      // E+3, seen at E+4
        chk("wr_vld", 64'(mc_rs_vld), 64'd1);
        chk("wr_cmd", 64'(mc_rs_cmd), 64'd3);
        chk("wr_tag", 64'(mc_rs_rtnctl), 64'h11);
        chk("wr_data", mc_rs_data, 64'd0);
        tick();
        chk("rd_vld", 64'(mc_rs_vld), 64'd1);
        chk("rd_cmd", 64'(mc_rs_cmd), 64'd2);
        chk("rd_tag", 64'(mc_rs_rtnctl), 64'h12);
        chk("rd_data", mc_rs_data, WDAT);
        tick();
        chk("rd_done_vld", 64'(mc_rs_vld), 64'd0);

        // Back-pressure fill: 20 attempted back-to-back reads
        mc_rs_stall = 1'b1;
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            rq(1, 3'd1, 48'h40, RW'(32'h100 + nacc), 64'd0, 0);
            acc = !mc_rq_stall;
            tick();
            if (acc) nacc++;
        end
        rq(0, 3'd0, 48'h0, 32'h0, 64'd0, 0);
        chk("bp_accepts", 64'(nacc), 64'd11);
        chk("bp_rqstall", 64'(mc_rq_stall), 64'd1);
        chk("bp_vld", 64'(mc_rs_vld), 64'd1);
        chk("bp_tag", 64'(mc_rs_rtnctl), 64'h100);
        chk("bp_data", mc_rs_data, WDAT);
        repeat (3) tick();
        chk("bp_frozen_tag", 64'(mc_rs_rtnctl), 64'h100);
        chk("bp_frozen_vld", 64'(mc_rs_vld), 64'd1);
        mc_rs_stall = 1'b0;
        collect(20);
        chk("bp_drain_n", 64'(got_n), 64'd11);
        for (int k = 0; k < 11; k++)
            chk($sformatf("bp_order%0d", k), 64'(got_tag[k]), 64'(32'h100 + k));
        chk("bp_rqstall_clr", 64'(mc_rq_stall), 64'd0);

        // Address wrap: 0x800 aliases word 0
        rq(1, 3'd2, 48'h0, 32'h21, 64'hAA, 0);
        tick();
        rq(1, 3'd2, 48'h800, 32'h22, 64'h55, 0);
        tick();
        rq(1, 3'd1, 48'h0, 32'h23, 64'd0, 0);
        tick();
        rq(0, 3'd0, 48'h0, 32'h0, 64'd0, 0);
        collect(10);
        chk("wrap_n", 64'(got_n), 64'd3);
        chk("wrap_wcmd", 64'(got_cmd[0]), 64'd3);
        chk("wrap_tag", 64'(got_tag[2]), 64'h23);
        chk("wrap_cmd", 64'(got_cmd[2]), 64'd2);
        chk("wrap_data", got_data[2], 64'h55);

        // Bad command, read, flush
        chk("err_before", 64'(err_cmd), 64'd0);
        rq(1, 3'd5, 48'h40, 32'h1, 64'd0, 0);
        tick();
        rq(1, 3'd1, 48'h40, 32'h2, 64'd0, 0);
        tick();
        rq(1, 3'd1, 48'h40, 32'h3, 64'h1234, 1);
        tick();
        rq(0, 3'd0, 48'h0, 32'h0, 64'd0, 0);
        collect(10);
        chk("bad_n", 64'(got_n), 64'd2);
        chk("bad_tag0", 64'(got_tag[0]), 64'h2);
        chk("bad_cmd0", 64'(got_cmd[0]), 64'd2);
        chk("bad_data0", got_data[0], WDAT);
        chk("flush_tag", 64'(got_tag[1]), 64'h3);
        chk("flush_cmd", 64'(got_cmd[1]), 64'd3);
        chk("flush_data", got_data[1], 64'd0);
        chk("err_after", 64'(err_cmd), 64'd1);

        // Reset mid-flight: queued/stalled work is discarded, store kept
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rq(1, 3'd1, 48'h40, RW'(32'h30 + i), 64'd0, 0);
            tick();
        end
        rq(0, 3'd0, 48'h0, 32'h0, 64'd0, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_vld", 64'(mc_rs_vld), 64'd0);
        chk("mid_rst_err", 64'(err_cmd), 64'd0);
        chk("mid_rst_data", mc_rs_data, 64'd0);
        tick();
        reset = 1'b0;
        mc_rs_stall = 1'b0;
        tick();
        chk("post_mid_vld", 64'(mc_rs_vld), 64'd0);
        rq(1, 3'd1, 48'h40, 32'h40, 64'd0, 0);
        tick();
        rq(0, 3'd0, 48'h0, 32'h0, 64'd0, 0);
        collect(12);
        chk("mid_n", 64'(got_n), 64'd1);
        chk("mid_tag", 64'(got_tag[0]), 64'h40);
        chk("mid_data", got_data[0], WDAT);
        chk("mid_err", 64'(err_cmd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
